// File: rtl/execute_stage.sv
// RV64I-Zba execute stage: operand forwarding, ALU with Zba address ops, and the E/M pipeline register
// with synchronous active-low reset, flush (bubble) and stall (hold).
module execute_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] PC_E,
  input  logic [XLEN-1:0] ImmExt_E,
  input  logic [4:0]      Rd_E,
  input  logic            RegWrite_E,
  input  logic            MemWrite_E,
  input  logic            ALUSrc_E,
  input  logic [1:0]      ResultSrc_E,
  input  logic [3:0]      ALUControl_E,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic [XLEN-1:0] Result_W,
  input  logic            Stall_M,
  input  logic            Flush_M,
  output logic [XLEN-1:0] ALUResult_M,
  output logic [XLEN-1:0] WriteData_M,
  output logic [XLEN-1:0] PCPlus4_M,
  output logic [4:0]      Rd_M,
  output logic            RegWrite_M,
  output logic            MemWrite_M,
  output logic [1:0]      ResultSrc_M
);

  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result, pc_plus4;
  logic [5:0]      shamt;

  logic [XLEN-1:0] alu_result_d, alu_result_q, write_data_d, write_data_q, pc_plus4_d, pc_plus4_q;
  logic [4:0]      rd_d, rd_q;
  logic            reg_write_d, reg_write_q, mem_write_d, mem_write_q;
  logic [1:0]      result_src_d, result_src_q;

  // Forwarding muxes; the 10 path uses this stage's own registered result (held value during stall)
  always_comb begin
    src_a = RD1_E;
    fwd_b = RD2_E;
    case (ForwardA_E)
      2'b01:   src_a = Result_W;
      2'b10:   src_a = alu_result_q;
      default: src_a = RD1_E;
    endcase
    case (ForwardB_E)
      2'b01:   fwd_b = Result_W;
      2'b10:   fwd_b = alu_result_q;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b    = ALUSrc_E ? ImmExt_E : fwd_b;
  assign shamt    = src_b[5:0];
  assign pc_plus4 = PC_E + {{(XLEN-3){1'b0}}, 3'b100};

  // ALU: base integer ops plus Zba shift-and-add; AUIPC bypasses forwarding entirely
  always_comb begin
    alu_result = {XLEN{1'b0}};
    case (ALUControl_E)
      4'b0000: alu_result = src_a + src_b;
      4'b0001: alu_result = src_a - src_b;
      4'b0010: alu_result = src_a & src_b;
      4'b0011: alu_result = src_a | src_b;
      4'b0100: alu_result = src_a ^ src_b;
      4'b0101: alu_result = src_a << shamt;
      4'b0110: alu_result = src_a >> shamt;
      4'b0111: alu_result = $unsigned($signed(src_a) >>> shamt);
      4'b1000: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'b1001: alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      4'b1010: alu_result = {src_a[XLEN-2:0], 1'b0} + src_b;
      4'b1011: alu_result = {src_a[XLEN-3:0], 2'b00} + src_b;
      4'b1100: alu_result = {src_a[XLEN-4:0], 3'b000} + src_b;
      4'b1101: alu_result = {{(XLEN-32){1'b0}}, src_a[31:0]} + src_b;
      4'b1110: alu_result = src_b;
      4'b1111: alu_result = PC_E + ImmExt_E;
      default: alu_result = {XLEN{1'b0}};
    endcase
  end

  // E/M next state: flush beats stall beats load
  always_comb begin
    alu_result_d = alu_result;
    write_data_d = fwd_b;
    pc_plus4_d   = pc_plus4;
    rd_d         = Rd_E;
    reg_write_d  = RegWrite_E;
    mem_write_d  = MemWrite_E;
    result_src_d = ResultSrc_E;
    if (Flush_M) begin
      alu_result_d = {XLEN{1'b0}};
      write_data_d = {XLEN{1'b0}};
      pc_plus4_d   = {XLEN{1'b0}};
      rd_d         = 5'd0;
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      result_src_d = 2'b00;
    end else if (Stall_M) begin
      alu_result_d = alu_result_q;
      write_data_d = write_data_q;
      pc_plus4_d   = pc_plus4_q;
      rd_d         = rd_q;
      reg_write_d  = reg_write_q;
      mem_write_d  = mem_write_q;
      result_src_d = result_src_q;
    end else begin
      alu_result_d = alu_result;
      write_data_d = fwd_b;
      pc_plus4_d   = pc_plus4;
      rd_d         = Rd_E;
      reg_write_d  = RegWrite_E;
      mem_write_d  = MemWrite_E;
      result_src_d = ResultSrc_E;
    end
  end

  // E/M pipeline register
  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_result_q <= {XLEN{1'b0}};
      write_data_q <= {XLEN{1'b0}};
      pc_plus4_q   <= {XLEN{1'b0}};
      rd_q         <= 5'd0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 2'b00;
    end else begin
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
    end
  end

  assign ALUResult_M = alu_result_q;
  assign WriteData_M = write_data_q;
  assign PCPlus4_M   = pc_plus4_q;
  assign Rd_M        = rd_q;
  assign RegWrite_M  = reg_write_q;
  assign MemWrite_M  = mem_write_q;
  assign ResultSrc_M = result_src_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors push hand-computed E/M contents,
// a monitor pops and compares one cycle later.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] RD1_E, RD2_E, PC_E, ImmExt_E, Result_W;
  logic [4:0]  Rd_E;
  logic        RegWrite_E, MemWrite_E, ALUSrc_E, Stall_M, Flush_M;
  logic [1:0]  ResultSrc_E, ForwardA_E, ForwardB_E;
  logic [3:0]  ALUControl_E;
  logic [63:0] ALUResult_M, WriteData_M, PCPlus4_M;
  logic [4:0]  Rd_M;
  logic        RegWrite_M, MemWrite_M;
  logic [1:0]  ResultSrc_M;

  execute_stage #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .RD1_E(RD1_E), .RD2_E(RD2_E), .PC_E(PC_E), .ImmExt_E(ImmExt_E),
    .Rd_E(Rd_E), .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E), .ALUSrc_E(ALUSrc_E),
    .ResultSrc_E(ResultSrc_E), .ALUControl_E(ALUControl_E), .ForwardA_E(ForwardA_E),
    .ForwardB_E(ForwardB_E), .Result_W(Result_W), .Stall_M(Stall_M), .Flush_M(Flush_M),
    .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M), .PCPlus4_M(PCPlus4_M), .Rd_M(Rd_M),
    .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M), .ResultSrc_M(ResultSrc_M)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    int          cyc;
    logic [63:0] alu;
    logic [63:0] wd;
    logic [63:0] pc4;
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one E/M register image per cycle, compared against the scoreboard head
  always @(posedge clk) begin
    #1;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL vec%0d stale: due cycle %0d, seen at %0d", e.id, e.cyc, cyc);
      end else if (ALUResult_M !== e.alu || WriteData_M !== e.wd || PCPlus4_M !== e.pc4 ||
                   Rd_M !== e.rd || RegWrite_M !== e.rw || MemWrite_M !== e.mw ||
                   ResultSrc_M !== e.rs) begin
        errors++;
        $display("FAIL vec%0d got alu=%h wd=%h pc4=%h rd=%0d rw=%b mw=%b rs=%b exp alu=%h wd=%h pc4=%h rd=%0d rw=%b mw=%b rs=%b",
                 e.id, ALUResult_M, WriteData_M, PCPlus4_M, Rd_M, RegWrite_M, MemWrite_M, ResultSrc_M,
                 e.alu, e.wd, e.pc4, e.rd, e.rw, e.mw, e.rs);
      end
    end
  end

  task automatic issue(input logic [63:0] alu, input logic [63:0] wd, input logic [63:0] pc4,
                       input logic [4:0] rd, input logic rw, input logic mw, input logic [1:0] rs);
    exp_t e;
    e.id = vec_id; e.cyc = cyc + 1;
    e.alu = alu; e.wd = wd; e.pc4 = pc4; e.rd = rd; e.rw = rw; e.mw = mw; e.rs = rs;
    exp_q.push_back(e);
    vec_id++;
    @(negedge clk);
  endtask

  task automatic op(input logic [3:0] ctl, input logic [63:0] a, input logic [63:0] b,
                    input logic src, input logic [63:0] imm);
    ALUControl_E = ctl; RD1_E = a; RD2_E = b; ALUSrc_E = src; ImmExt_E = imm;
  endtask

  initial begin
    rst = 1'b0; RD1_E = 64'd0; RD2_E = 64'd0; PC_E = 64'd0; ImmExt_E = 64'd0; Result_W = 64'd0;
    Rd_E = 5'd0; RegWrite_E = 1'b0; MemWrite_E = 1'b0; ALUSrc_E = 1'b0; ResultSrc_E = 2'b00;
    ALUControl_E = 4'b0000; ForwardA_E = 2'b00; ForwardB_E = 2'b00; Stall_M = 1'b0; Flush_M = 1'b0;
    @(negedge clk);

    // reset held two cycles with live inputs
    op(4'b0000, 64'd5, 64'd7, 1'b0, 64'd0); Rd_E = 5'd1; RegWrite_E = 1'b1;
    issue(64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 2'b00);
    issue(64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 2'b00);
    rst = 1'b1;

    // basic ops
    issue(64'd12, 64'd7, 64'd4, 5'd1, 1'b1, 1'b0, 2'b00);
    op(4'b0001, 64'd0, 64'd1, 1'b0, 64'd0);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd4, 5'd1, 1'b1, 1'b0, 2'b00);
    op(4'b0010, 64'hF0F0, 64'hFF00, 1'b0, 64'd0);
    issue(64'hF000, 64'hFF00, 64'd4, 5'd1, 1'b1, 1'b0, 2'b00);
    op(4'b0011, 64'hF0F0, 64'hFF00, 1'b0, 64'd0);
    issue(64'hFFF0, 64'hFF00, 64'd4, 5'd1, 1'b1, 1'b0, 2'b00);
    op(4'b0100, 64'hF0F0, 64'hFF00, 1'b0, 64'd0);
    issue(64'h0FF0, 64'hFF00, 64'd4, 5'd1, 1'b1, 1'b0, 2'b00);

    // Zba
    op(4'b1100, 64'h10, 64'h1000, 1'b0, 64'd0);
    issue(64'h1080, 64'h1000, 64'd4, 5'd1, 1'b1, 1'b0, 2'b00);
    op(4'b1101, 64'hFFFF_FFFF_8000_0000, 64'd1, 1'b0, 64'd0);
    issue(64'h8000_0001, 64'd1, 64'd4, 5'd1, 1'b1, 1'b0, 2'b00);
    op(4'b1010, 64'h8000_0000_0000_0000, 64'd3, 1'b0, 64'd0);
    issue(64'd3, 64'd3, 64'd4, 5'd1, 1'b1, 1'b0, 2'b00);
    op(4'b1011, 64'h3, 64'h5, 1'b0, 64'd0);
    issue(64'h11, 64'h5, 64'd4, 5'd1, 1'b1, 1'b0, 2'b00);

    // back-to-back forwarding from own ALUResult_M
    op(4'b0000, 64'd4, 64'd5, 1'b0, 64'd0);
    issue(64'd9, 64'd5, 64'd4, 5'd1, 1'b1, 1'b0, 2'b00);
    ForwardA_E = 2'b10; op(4'b0000, 64'd0, 64'h77, 1'b1, 64'd1); Rd_E = 5'd2;
    issue(64'd10, 64'h77, 64'd4, 5'd2, 1'b1, 1'b0, 2'b00);

    // ForwardB from writeback; ForwardA=11 reads RD1
    ForwardA_E = 2'b11; ForwardB_E = 2'b01; Result_W = 64'h55; MemWrite_E = 1'b1; RegWrite_E = 1'b0;
    op(4'b0000, 64'h100, 64'h999, 1'b1, 64'd8); ResultSrc_E = 2'b01;
    issue(64'h108, 64'h55, 64'd4, 5'd2, 1'b0, 1'b1, 2'b01);
    ForwardA_E = 2'b00; ForwardB_E = 2'b00; MemWrite_E = 1'b0; RegWrite_E = 1'b1; ResultSrc_E = 2'b00;

    // shifts and compares
    op(4'b0111, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 64'h43);
    issue(64'hF000_0000_0000_0000, 64'd0, 64'd4, 5'd2, 1'b1, 1'b0, 2'b00);
    op(4'b0110, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 64'h4);
    issue(64'h0800_0000_0000_0000, 64'd0, 64'd4, 5'd2, 1'b1, 1'b0, 2'b00);
    op(4'b0101, 64'd1, 64'd0, 1'b1, 64'h41);
    issue(64'd2, 64'd0, 64'd4, 5'd2, 1'b1, 1'b0, 2'b00);
    op(4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 64'd0);
    issue(64'd1, 64'd0, 64'd4, 5'd2, 1'b1, 1'b0, 2'b00);
    op(4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 64'd0);
    issue(64'd0, 64'd0, 64'd4, 5'd2, 1'b1, 1'b0, 2'b00);
    op(4'b1110, 64'd9, 64'h33, 1'b1, 64'h1234_5000);
    issue(64'h1234_5000, 64'h33, 64'd4, 5'd2, 1'b1, 1'b0, 2'b00);

    // PC ops: AUIPC ignores forwarding
    ForwardA_E = 2'b01; Result_W = 64'h77; PC_E = 64'h1000;
    op(4'b1111, 64'd5, 64'd0, 1'b1, 64'h2000);
    issue(64'h3000, 64'd0, 64'h1004, 5'd2, 1'b1, 1'b0, 2'b00);
    ForwardA_E = 2'b00; PC_E = 64'hFFFF_FFFF_FFFF_FFFC;
    op(4'b0000, 64'd1, 64'd1, 1'b0, 64'd0);
    issue(64'd2, 64'd1, 64'd0, 5'd2, 1'b1, 1'b0, 2'b00);
    PC_E = 64'd0;

    // stall holds for three cycles while inputs change
    op(4'b0000, 64'h20, 64'd0, 1'b0, 64'd0); Rd_E = 5'd5; ResultSrc_E = 2'b01;
    issue(64'h20, 64'd0, 64'd4, 5'd5, 1'b1, 1'b0, 2'b01);
    Stall_M = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op(4'b0001, 64'(i + 100), 64'd1, 1'b0, 64'd0); PC_E = 64'h40; Rd_E = 5'(i + 9); MemWrite_E = 1'b1;
      issue(64'h20, 64'd0, 64'd4, 5'd5, 1'b1, 1'b0, 2'b01);
    end
    // forwarding during stall sees held value, then load after release
    Stall_M = 1'b0; MemWrite_E = 1'b0; PC_E = 64'd0; Rd_E = 5'd6; ResultSrc_E = 2'b00;
    ForwardA_E = 2'b10; op(4'b0000, 64'd0, 64'd1, 1'b0, 64'd0);
    issue(64'h21, 64'd1, 64'd4, 5'd6, 1'b1, 1'b0, 2'b00);
    ForwardA_E = 2'b00;

    // flush + stall together: flush wins
    MemWrite_E = 1'b1; ResultSrc_E = 2'b10; Stall_M = 1'b1; Flush_M = 1'b1;
    op(4'b0000, 64'd3, 64'd4, 1'b0, 64'd0);
    issue(64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 2'b00);
    Stall_M = 1'b0; Flush_M = 1'b0; Rd_E = 5'd3;
    issue(64'd7, 64'd4, 64'd4, 5'd3, 1'b1, 1'b1, 2'b10);

    // mid-stream reset discards in-flight op, next posedge after release loads
    rst = 1'b0; op(4'b0000, 64'd8, 64'd8, 1'b0, 64'd0);
    issue(64'd0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 2'b00);
    rst = 1'b1;
    issue(64'd16, 64'd8, 64'd4, 5'd3, 1'b1, 1'b1, 2'b10);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, 0 required", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
